// File: rtl/uio_bus_arbiter_if.sv
// uio_bus_arbiter_if
//   Bundles the requester handshake, the uio pad signals and the arbiter
//   status outputs shared between two requesters and a uio pad ring.
//   The clock and reset are not part of the bundle.
//
//   master (requester/pad side) drives:
//     ena, r0_req, r1_req, r0_oe, r0_out, r1_oe, r1_out, uio_in
//   slave (arbiter side) drives:
//     r0_gnt, r1_gnt, uio_out, uio_oe, rd_data, busy
interface uio_bus_arbiter_if;
  logic       ena;
  logic       r0_req;
  logic       r1_req;
  logic [7:0] r0_oe;
  logic [7:0] r0_out;
  logic [7:0] r1_oe;
  logic [7:0] r1_out;
  logic       r0_gnt;
  logic       r1_gnt;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] rd_data;
  logic       busy;

  modport master (
    output ena, r0_req, r1_req, r0_oe, r0_out, r1_oe, r1_out, uio_in,
    input  r0_gnt, r1_gnt, uio_out, uio_oe, rd_data, busy
  );

  modport slave (
    input  ena, r0_req, r1_req, r0_oe, r0_out, r1_oe, r1_out, uio_in,
    output r0_gnt, r1_gnt, uio_out, uio_oe, rd_data, busy
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter
//   Arbitrates ownership of the 8 uio pins between two requesters.
//   A new owner is always preceded by TURNAROUND idle (oe=0) cycles so
//   two drivers never overlap on the pads. A contested owner is preempted
//   after MAX_HOLD grant cycles; an uncontested owner keeps the pins.
//   Ties go to the requester that did not own the pins last.
//
//   Parameters
//     TURNAROUND  idle cycles before a new grant (0..15)
//     MAX_HOLD    grant cycles before a contested owner is preempted (1..255)
//   Ports
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    uio_bus_arbiter_if.slave:
//              ena        design enable, low forces release
//              rN_req     requester N wants the pins
//              rN_oe/out  requester N per-pin enable / drive data
//              rN_gnt     requester N owns the pins
//              uio_in     pad input; rd_data is it registered once
//              uio_out/oe pad data / enable (1 = output)
//              busy       arbiter is not idle
module uio_bus_arbiter #(
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  uio_bus_arbiter_if.slave    bus
);

  localparam logic [3:0] TURN_INIT = 4'(TURNAROUND);
  localparam logic [7:0] HOLD_LIM  = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

  state_t     state;
  logic       owner;
  logic       last;
  logic [3:0] tcnt;
  logic [7:0] hcnt;

  logic own_req;
  logic oth_req;
  logic idle_win;

  assign own_req  = owner ? bus.r1_req : bus.r0_req;
  assign oth_req  = owner ? bus.r0_req : bus.r1_req;
  // Sole requester wins; on a tie the one that did not own last wins.
  assign idle_win = (bus.r0_req && bus.r1_req) ? ~last : bus.r1_req;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      tcnt  <= '0;
      hcnt  <= '0;
    end else if (!bus.ena) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.r0_req || bus.r1_req) begin
            owner <= idle_win;
            tcnt  <= TURN_INIT;
            if (TURNAROUND == 0) begin
              state <= OWN;
              last  <= idle_win;
              hcnt  <= '0;
            end else begin
              state <= TURN;
            end
          end
        end

        TURN: begin
          tcnt <= tcnt - 4'd1;
          // tcnt is never 0 here; treating <=1 as done guards against a stall.
          if (tcnt <= 4'd1) begin
            state <= OWN;
            last  <= owner;
            hcnt  <= '0;
          end
        end

        OWN: begin
          if (hcnt != 8'hFF) hcnt <= hcnt + 8'd1;
          // Release and preemption both hand over when the other is waiting.
          if (oth_req && (!own_req || hcnt >= HOLD_LIM)) begin
            owner <= ~owner;
            tcnt  <= TURN_INIT;
            if (TURNAROUND == 0) begin
              state <= OWN;
              last  <= ~owner;
              hcnt  <= '0;
            end else begin
              state <= TURN;
            end
          end else if (!own_req) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rd_data <= '0;
    else        bus.rd_data <= bus.uio_in;
  end

  // Outputs decode registered state only, so the async reset clears the
  // pads immediately without waiting for an edge.
  assign bus.r0_gnt = (state == OWN) && !owner;
  assign bus.r1_gnt = (state == OWN) &&  owner;
  assign bus.busy   = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bus.uio_oe  = '0;
    bus.uio_out = '0;
    if (state == OWN) begin
      bus.uio_oe  = owner ? bus.r1_oe  : bus.r0_oe;
      bus.uio_out = owner ? bus.r1_out : bus.r0_out;
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter
//   Directed checks of the arbiter with TURNAROUND=1, MAX_HOLD=4, followed
//   by random traffic checked against mutual-exclusion invariants.
module tb_uio_bus_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  uio_bus_arbiter_if bus ();

  uio_bus_arbiter #(
    .TURNAROUND (1),
    .MAX_HOLD   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 time
  // unit later, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [7:0] prev_in;
  logic       prev_ena;

  initial begin
    checks = 0;
    errors = 0;

    bus.ena    = 1'b1;
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    bus.r0_oe  = 8'h00;
    bus.r0_out = 8'h00;
    bus.r1_oe  = 8'h00;
    bus.r1_out = 8'h00;
    bus.uio_in = 8'h3C;
    rst_n      = 1'b0;

    // Reset state, held across an edge.
    step();
    check("rst_r0_gnt",  8'(bus.r0_gnt), 8'h00);
    check("rst_r1_gnt",  8'(bus.r1_gnt), 8'h00);
    check("rst_uio_oe",  bus.uio_oe,     8'h00);
    check("rst_uio_out", bus.uio_out,    8'h00);
    check("rst_busy",    8'(bus.busy),   8'h00);
    check("rst_rd_data", bus.rd_data,    8'h00);
    rst_n = 1'b1;
    step();
    check("rd_data_load", bus.rd_data, 8'h3C);

    // Single requester: busy after one edge, grant after two.
    bus.r0_req = 1'b1;
    bus.r0_oe  = 8'hFF;
    bus.r0_out = 8'hA5;
    bus.uio_in = 8'h5A;
    step();
    check("single_busy",    8'(bus.busy),   8'h01);
    check("single_turn_g0", 8'(bus.r0_gnt), 8'h00);
    check("single_turn_oe", bus.uio_oe,     8'h00);
    check("rd_data_5a",     bus.rd_data,    8'h5A);
    step();
    check("single_gnt",  8'(bus.r0_gnt), 8'h01);
    check("single_g1",   8'(bus.r1_gnt), 8'h00);
    check("single_oe",   bus.uio_oe,     8'hFF);
    check("single_out",  bus.uio_out,    8'hA5);

    // Uncontested owner holds for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      step();
      check("hold_r0_gnt", 8'(bus.r0_gnt), 8'h01);
    end

    // r1 arrives; r0 has long exceeded MAX_HOLD so it drops on the next edge.
    bus.r1_req = 1'b1;
    bus.r1_oe  = 8'h0F;
    bus.r1_out = 8'h33;
    step();
    check("preempt_r0_drop", 8'(bus.r0_gnt), 8'h00);
    check("preempt_r1_wait", 8'(bus.r1_gnt), 8'h00);
    check("preempt_turn_oe", bus.uio_oe,     8'h00);
    check("preempt_busy",    8'(bus.busy),   8'h01);
    step();
    check("preempt_r1_gnt", 8'(bus.r1_gnt), 8'h01);
    check("preempt_r1_oe",  bus.uio_oe,     8'h0F);
    check("preempt_r1_out", bus.uio_out,    8'h33);

    // Contested r1 keeps the pins for exactly MAX_HOLD OWN cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_lim_r1", 8'(bus.r1_gnt), 8'h01);
    end
    step();
    check("hold_lim_drop", 8'(bus.r1_gnt), 8'h00);
    check("hold_lim_oe",   bus.uio_oe,     8'h00);
    step();
    check("hold_lim_r0", 8'(bus.r0_gnt), 8'h01);

    // Release with r1 pending hands over through one turn cycle.
    bus.r0_req = 1'b0;
    step();
    check("release_r0", 8'(bus.r0_gnt), 8'h00);
    check("release_oe", bus.uio_oe,     8'h00);
    check("release_r1", 8'(bus.r1_gnt), 8'h00);
    step();
    check("release_r1_gnt", 8'(bus.r1_gnt), 8'h01);

    // ena drop forces release and blocks new grants.
    bus.ena    = 1'b0;
    bus.r0_req = 1'b1;
    step();
    check("ena_r1_drop", 8'(bus.r1_gnt), 8'h00);
    check("ena_oe",      bus.uio_oe,     8'h00);
    check("ena_busy",    8'(bus.busy),   8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ena_no_busy", 8'(bus.busy), 8'h00);
    end
    // Tie after r1 owned last: r0 wins, TURNAROUND+1 edges after ena rises.
    bus.ena = 1'b1;
    step();
    check("ena_resume_turn", 8'(bus.busy),   8'h01);
    check("ena_resume_nog",  8'(bus.r0_gnt), 8'h00);
    step();
    check("ena_resume_r0", 8'(bus.r0_gnt), 8'h01);
    check("ena_resume_oe", bus.uio_oe,     8'hFF);

    // Both release: back to idle.
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    step();
    check("idle_busy", 8'(bus.busy), 8'h00);
    check("idle_oe",   bus.uio_oe,   8'h00);

    // Dropping req during the turn still completes into OWN, then releases.
    bus.r0_req = 1'b1;
    step();
    check("turn_drop_turn", 8'(bus.busy), 8'h01);
    bus.r0_req = 1'b0;
    step();
    check("turn_drop_own", 8'(bus.r0_gnt), 8'h01);
    step();
    check("turn_drop_rel",  8'(bus.r0_gnt), 8'h00);
    check("turn_drop_idle", 8'(bus.busy),   8'h00);

    // Async reset mid-grant clears the pads before the next edge.
    bus.r0_req = 1'b1;
    bus.r0_oe  = 8'h0F;
    step_n(2);
    check("areset_pre_gnt", 8'(bus.r0_gnt), 8'h01);
    check("areset_pre_oe",  bus.uio_oe,     8'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_oe",   bus.uio_oe,     8'h00);
    check("areset_gnt",  8'(bus.r0_gnt), 8'h00);
    check("areset_busy", 8'(bus.busy),   8'h00);
    // r0 owned last, but reset restores last=1, so a tie goes to r0.
    bus.r1_req = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    check("tie_turn", 8'(bus.busy), 8'h01);
    step();
    check("tie_r0_gnt", 8'(bus.r0_gnt), 8'h01);
    check("tie_r1_gnt", 8'(bus.r1_gnt), 8'h00);
    bus.r0_req = 1'b0;
    step();
    check("tie_handover_oe", bus.uio_oe,     8'h00);
    check("tie_handover_r0", 8'(bus.r0_gnt), 8'h00);
    step();
    check("tie_r1_after", 8'(bus.r1_gnt), 8'h01);
    check("tie_r1_oe",    bus.uio_oe,     8'h0F);

    // Random traffic with invariant checks every cycle.
    prev_in  = bus.uio_in;
    prev_ena = bus.ena;
    for (int i = 0; i < 10000; i++) begin
      step();
      check("rnd_rd_data", bus.rd_data, prev_in);
      check("rnd_mutex", 8'(bus.r0_gnt && bus.r1_gnt), 8'h00);
      if (!prev_ena)
        check("rnd_ena_nog", 8'(bus.r0_gnt || bus.r1_gnt), 8'h00);
      if (bus.r0_gnt)
        check("rnd_oe_r0", bus.uio_oe, bus.r0_oe);
      else if (bus.r1_gnt)
        check("rnd_oe_r1", bus.uio_oe, bus.r1_oe);
      else
        check("rnd_oe_idle", bus.uio_oe, 8'h00);
      bus.ena    = ($urandom_range(15) != 0);
      bus.r0_req = 1'($urandom_range(1));
      bus.r1_req = 1'($urandom_range(1));
      bus.r0_oe  = 8'($urandom);
      bus.r0_out = 8'($urandom);
      bus.r1_oe  = 8'($urandom);
      bus.r1_out = 8'($urandom);
      bus.uio_in = 8'($urandom);
      prev_in    = bus.uio_in;
      prev_ena   = bus.ena;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uio_bus_arbiter.md
UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

Interface
REQ-001 The block SHALL have parameter TURNAROUND, default 1: idle (oe=0) cycles inserted before any new grant; legal range 0..15.
REQ-002 The block SHALL have parameter MAX_HOLD, default 16: grant cycles after which a contested owner is preempted; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port ena, input, 1 bit: design enable; low forces release.
REQ-006 The block SHALL have ports r0_req and r1_req, input, 1 bit each: requester wants the uio pins.
REQ-007 The block SHALL have ports r0_oe, r0_out, r1_oe and r1_out, input, 8 bits each: requester per-pin enable (1=drive) and drive data.
REQ-008 The block SHALL have ports r0_gnt and r1_gnt, output, 1 bit each: requester owns the pins.
REQ-009 The block SHALL have port uio_in, input, 8 bits: pad input path.
REQ-010 The block SHALL have ports uio_out and uio_oe, output, 8 bits each: pad output data and enable, where 1 = output.
REQ-011 The block SHALL have port rd_data, output, 8 bits: uio_in registered once.
REQ-012 The block SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-013 The block SHALL implement exactly three FSM states: IDLE, TURN and OWN, plus registers owner (1 bit), last (1 bit), tcnt (4 bits) and hcnt (8 bits).
REQ-014 In IDLE with ena=1 and any req high, the block SHALL select a winner, load tcnt=TURNAROUND, and go to TURN, or go directly to OWN when TURNAROUND=0.
REQ-015 Winner selection SHALL be: the sole requester; if both request, the one not equal to last.
REQ-016 In TURN, uio_oe SHALL be 0 and tcnt SHALL decrement each cycle; when tcnt reaches 1, the next state SHALL be OWN.
REQ-017 Latency SHALL be: req high at edge N in IDLE gives gnt high after edge N+TURNAROUND+1.
REQ-018 Entry into OWN SHALL set last=owner and hcnt=0; hcnt SHALL increment each OWN cycle and saturate at 255.
REQ-019 rN_gnt SHALL equal (state==OWN && owner==N) and SHALL be registered-state decode only.
REQ-020 uio_oe and uio_out SHALL equal the owner's oe/out combinationally while in OWN, and uio_oe SHALL be 0x00 in IDLE and TURN; uio_out SHALL be 0x00 when not in OWN.
REQ-021 Release SHALL occur when the owner's req=0 in OWN: if the other requester is pending, go to TURN with the new owner; otherwise go to IDLE.
REQ-022 Preemption SHALL occur in OWN when the other req=1 and hcnt ≥ MAX_HOLD-1: go to TURN with the other owner, and gnt SHALL drop on that edge.
REQ-023 An uncontested owner SHALL keep the grant indefinitely, with no preemption.
REQ-024 When release and preemption conditions coincide, the outcome SHALL be identical: a handover to the other requester.
REQ-025 A requester dropping req in TURN SHALL be handled as follows: the turn completes, OWN is entered, and it is released on the next edge; there SHALL be no abort.
REQ-026 ena=0 SHALL force state IDLE on the next edge from any state, with gnt and uio_oe low from that edge, and no new grants while ena=0.
REQ-027 rd_data SHALL be loaded with uio_in every cycle, regardless of state.
REQ-028 No cycle SHALL have both grants high, and no cycle SHALL drive uio_oe from a non-owner.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously set state=IDLE, owner=0, last=1 (r0 wins the first tie), tcnt=0, hcnt=0 and rd_data=0x00.
REQ-030 During reset, the outputs SHALL be r0_gnt=r1_gnt=0, uio_oe=0x00, uio_out=0x00 and busy=0.
REQ-031 Reset asserted mid-grant SHALL release the pins immediately, without waiting for a clock edge.
REQ-032 Operation SHALL resume on the first rising edge after rst_n rises.

Verification
REQ-033 Single requester: with TURNAROUND=1, r0_req=1 at edge 0 and r0_oe=0xFF, r0_out=0xA5 -> busy=1 at edge 1, r0_gnt=1 after edge 2, uio_oe=0xFF, uio_out=0xA5.
REQ-034 Tie: r0_req=r1_req=1 from reset -> r0 granted first; r0 drops req -> uio_oe=0x00 for 1 turn cycle, then r1_gnt=1.
REQ-035 Preemption: MAX_HOLD=4, r0 holds, r1_req rises -> r0_gnt falls no later than 4 OWN cycles after r1_req rises, then 1 idle cycle, then r1_gnt=1; with r1_req=0, r0 is held for 100 cycles without a drop.
REQ-036 ena drop: ena=0 during r1 ownership -> r1_gnt=0 and uio_oe=0x00 after the next edge; no grant while ena=0; a grant resumes TURNAROUND+1 cycles after ena=1.
REQ-037 Async reset: rst_n pulsed low mid-cycle while r0 owns with uio_oe=0x0F -> uio_oe=0x00 and r0_gnt=0 before the next clk edge; after release, a tie is granted to r0.
REQ-038 Mutual exclusion: random req/ena traffic for 10,000 cycles -> never both gnt=1, uio_oe=0 whenever gnt=0, and rd_data always equals the previous cycle's uio_in.
